// File: rtl/lcd_text_writer.sv
// Byte-stream front end for the lcd16x2 driver: FIFO, 2xCOLS cursor tracking, control-code decode.
// Define LCD_TEXT_WRITER_AUTOWRAP_EN to wrap to the other row after the last column instead of discarding.
module lcd_text_writer #(
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter int unsigned COLS             = 16,
    parameter logic [7:0]  LCD_SETDDRAMADDR = 8'h80,
    parameter logic [7:0]  LCD_ROW_OFFSET   = 8'h40,
    parameter logic [7:0]  LCD_CLEARDISPLAY = 8'h01
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [7:0]                 char_i,
    input  logic                       char_valid_i,
    output logic                       char_ready_o,
    output logic [7:0]                 lcd_data_o,
    output logic [1:0]                 lcd_ops_o,
    output logic                       lcd_enb_o,
    input  logic                       lcd_rdy_i,
    output logic                       row_o,
    output logic [$clog2(COLS+1)-1:0]  col_o,
    output logic                       busy_o
);

    localparam int unsigned CW = $clog2(COLS + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = $clog2(FIFO_DEPTH + 1);

    localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);
    localparam logic [CW-1:0] COLS_C   = CW'(COLS);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [1:0]    OPS_CHAR = 2'd1;
    localparam logic [1:0]    OPS_CMD  = 2'd3;

    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_FF = 8'h0C;
    localparam logic [7:0] CHAR_SP = 8'h20;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_e;

    logic [7:0]    fifoMem_q [FIFO_DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [NW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          push;
    logic          pop;
    logic [7:0]    headByte;

    state_e        state_q, state_d;
    logic          row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    ops_q, ops_d;
    logic          enb_q, enb_d;
    logic          pend_q, pend_d;
    logic [7:0]    pendData_q, pendData_d;

    function automatic logic [7:0] rowAddr(input logic r);
        return LCD_SETDDRAMADDR | (r ? LCD_ROW_OFFSET : 8'h00);
    endfunction

    assign push     = char_valid_i && ready_q;
    assign headByte = fifoMem_q[rdPtr_q];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= char_i;
        end
    end

    // Ready is registered from the next count so it drops right after the filling push.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != FULL_CNT);
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        data_d     = data_q;
        ops_d      = ops_q;
        enb_d      = enb_q;
        pend_d     = pend_q;
        pendData_d = pendData_q;
        pop        = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (lcd_rdy_i) begin
                    data_d  = LCD_SETDDRAMADDR;
                    ops_d   = OPS_CMD;
                    enb_d   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end

            ST_IDLE: begin
                if ((count_q != '0) && lcd_rdy_i) begin
                    pop = 1'b1;
                    if (headByte == CHAR_LF) begin
                        row_d   = ~row_q;
                        col_d   = '0;
                        data_d  = rowAddr(~row_q);
                        ops_d   = OPS_CMD;
                        enb_d   = 1'b1;
                        state_d = ST_ISSUE;
                    end else if (headByte == CHAR_CR) begin
                        col_d   = '0;
                        data_d  = rowAddr(row_q);
                        ops_d   = OPS_CMD;
                        enb_d   = 1'b1;
                        state_d = ST_ISSUE;
                    end else if (headByte == CHAR_FF) begin
                        row_d   = 1'b0;
                        col_d   = '0;
                        data_d  = LCD_CLEARDISPLAY;
                        ops_d   = OPS_CMD;
                        enb_d   = 1'b1;
                        state_d = ST_ISSUE;
                    end else if (headByte >= CHAR_SP) begin
                        if (col_q < COLS_C) begin
                            data_d  = headByte;
                            ops_d   = OPS_CHAR;
                            enb_d   = 1'b1;
                            state_d = ST_ISSUE;
`ifdef LCD_TEXT_WRITER_AUTOWRAP_EN
                            if (col_q == LAST_COL) begin
                                col_d      = '0;
                                row_d      = ~row_q;
                                pend_d     = 1'b1;
                                pendData_d = rowAddr(~row_q);
                            end else begin
                                col_d = col_q + CW'(1);
                            end
`else
                            col_d = col_q + CW'(1);
`endif
                        end
                    end
                end
            end

            ST_ISSUE: begin
                if (!lcd_rdy_i) begin
                    enb_d   = 1'b0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (lcd_rdy_i) begin
                    if (pend_q) begin
                        data_d  = pendData_q;
                        ops_d   = OPS_CMD;
                        enb_d   = 1'b1;
                        pend_d  = 1'b0;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            state_q    <= ST_INIT;
            row_q      <= 1'b0;
            col_q      <= '0;
            data_q     <= '0;
            ops_q      <= '0;
            enb_q      <= 1'b0;
            pend_q     <= 1'b0;
            pendData_q <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            data_q     <= data_d;
            ops_q      <= ops_d;
            enb_q      <= enb_d;
            pend_q     <= pend_d;
            pendData_q <= pendData_d;
        end
    end

    assign char_ready_o = ready_q;
    assign lcd_data_o   = data_q;
    assign lcd_ops_o    = ops_q;
    assign lcd_enb_o    = enb_q;
    assign row_o        = row_q;
    assign col_o        = col_q;
    assign busy_o       = (state_q != ST_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed testbench for lcd_text_writer against a 1-cycle-busy lcd16x2 model.
// Build with LCD_TEXT_WRITER_AUTOWRAP_EN defined to exercise the autowrap expectations.
module tb_lcd_text_writer;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [7:0] charIn = 8'h00;
    logic       charValid = 1'b0;
    logic       charReady;
    logic [7:0] lcdData;
    logic [1:0] lcdOps;
    logic       lcdEnb;
    logic       lcdRdy;
    logic       row;
    logic [4:0] col;
    logic       busy;

    logic       rdyQ = 1'b1;
    logic       stall = 1'b0;
    logic       enbPrev = 1'b0;
    logic [9:0] txQ [$];

    int checks = 0;
    int errors = 0;

    lcd_text_writer dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .char_i       (charIn),
        .char_valid_i (charValid),
        .char_ready_o (charReady),
        .lcd_data_o   (lcdData),
        .lcd_ops_o    (lcdOps),
        .lcd_enb_o    (lcdEnb),
        .lcd_rdy_i    (lcdRdy),
        .row_o        (row),
        .col_o        (col),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // LCD model: goes busy for one cycle after seeing enb while ready; stall forces it not-ready.
    assign lcdRdy = rdyQ && !stall;

    always @(posedge clk) begin
        if (lcdEnb && lcdRdy) begin
            rdyQ <= 1'b0;
        end else if (!rdyQ) begin
            rdyQ <= 1'b1;
        end
    end

    // Record every transaction as {ops, data} on the enb rising edge.
    always @(posedge clk) begin
        if (lcdEnb && !enbPrev) begin
            txQ.push_back({lcdOps, lcdData});
        end
        enbPrev <= lcdEnb;
    end

    task automatic pushByte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        charIn    = b;
        charValid = 1'b1;
        while (charReady !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (charReady !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout: byte %h, ready %b, required 1", b, charReady);
            charValid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            charValid = 1'b0;
        end
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_idle_timeout: busy %b, required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (charReady !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready: got %b required 0", charReady); end
        checks++; if (lcdEnb !== 1'b0) begin errors++; $display("[TB] FAIL rst_enb: got %b required 0", lcdEnb); end
        checks++; if (lcdData !== 8'h00 || lcdOps !== 2'd0) begin errors++; $display("[TB] FAIL rst_data_ops: got %h/%0d required 00/0", lcdData, lcdOps); end
        checks++; if (row !== 1'b0 || col !== 5'd0) begin errors++; $display("[TB] FAIL rst_cursor: got %b/%0d required 0/0", row, col); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_busy: got %b required 1", busy); end
        rstN = 1'b1;
        waitIdle("init");
        checks++; if (txQ.size() !== 1) begin errors++; $display("[TB] FAIL init_count: got %0d required 1", txQ.size()); end
        else begin
            checks++; if (txQ[0] !== 10'h380) begin errors++; $display("[TB] FAIL init_cmd: got %h required 380", txQ[0]); end
        end
        checks++; if (busy !== 1'b0 || charReady !== 1'b1) begin errors++; $display("[TB] FAIL init_idle: busy %b ready %b required 0 1", busy, charReady); end
        txQ.delete();
    endtask

    task automatic test_hi();
        @(negedge clk);
        charIn    = 8'h48;
        charValid = 1'b1;
        @(posedge clk);
        #1;
        charValid = 1'b0;
        checks++; if (lcdEnb !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL hi_n1: enb %b busy %b required 0 1", lcdEnb, busy); end
        @(posedge clk);
        #1;
        checks++; if (lcdEnb !== 1'b1 || lcdData !== 8'h48 || lcdOps !== 2'd1) begin
            errors++; $display("[TB] FAIL hi_n2: enb %b data %h ops %0d required 1 48 1", lcdEnb, lcdData, lcdOps);
        end
        checks++; if (col !== 5'd1) begin errors++; $display("[TB] FAIL hi_col_on_pop: got %0d required 1", col); end
        pushByte(8'h49);
        waitIdle("hi");
        checks++; if (txQ.size() !== 2) begin errors++; $display("[TB] FAIL hi_count: got %0d required 2", txQ.size()); end
        else begin
            checks++; if (txQ[0] !== 10'h148 || txQ[1] !== 10'h149) begin errors++; $display("[TB] FAIL hi_tx: got %h %h required 148 149", txQ[0], txQ[1]); end
        end
        checks++; if (col !== 5'd2 || row !== 1'b0) begin errors++; $display("[TB] FAIL hi_cursor: got %b/%0d required 0/2", row, col); end
        txQ.delete();
    endtask

    task automatic test_wrap();
        logic [9:0] exp [$];
        logic       expRow;
        logic [4:0] expCol;
        exp.push_back(10'h301);
        for (int i = 0; i < 16; i++) exp.push_back(10'h141);
`ifdef LCD_TEXT_WRITER_AUTOWRAP_EN
        exp.push_back(10'h3C0);
        exp.push_back(10'h141);
        expRow = 1'b1;
        expCol = 5'd1;
`else
        expRow = 1'b0;
        expCol = 5'd16;
`endif
        pushByte(8'h0C);
        for (int i = 0; i < 17; i++) pushByte(8'h41);
        waitIdle("wrap");
        checks++; if (txQ.size() !== exp.size()) begin errors++; $display("[TB] FAIL wrap_count: got %0d required %0d", txQ.size(), exp.size()); end
        else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++; if (txQ[i] !== exp[i]) begin errors++; $display("[TB] FAIL wrap_tx%0d: got %h required %h", i, txQ[i], exp[i]); end
            end
        end
        checks++; if (row !== expRow || col !== expCol) begin errors++; $display("[TB] FAIL wrap_cursor: got %b/%0d required %b/%0d", row, col, expRow, expCol); end
        txQ.delete();
    endtask

    task automatic test_controls();
        logic [9:0] exp [$];
        exp = '{10'h301, 10'h141, 10'h3C0, 10'h142, 10'h301};
        pushByte(8'h0C);
        pushByte(8'h41);
        pushByte(8'h0A);
        pushByte(8'h42);
        pushByte(8'h0C);
        waitIdle("ctrl");
        checks++; if (txQ.size() !== exp.size()) begin errors++; $display("[TB] FAIL ctrl_count: got %0d required %0d", txQ.size(), exp.size()); end
        else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++; if (txQ[i] !== exp[i]) begin errors++; $display("[TB] FAIL ctrl_tx%0d: got %h required %h", i, txQ[i], exp[i]); end
            end
        end
        checks++; if (row !== 1'b0 || col !== 5'd0) begin errors++; $display("[TB] FAIL ctrl_cursor: got %b/%0d required 0/0", row, col); end
        txQ.delete();
    endtask

    task automatic test_cr_nonprint();
        logic [9:0] exp [$];
        exp = '{10'h3C0, 10'h15A, 10'h3C0, 10'h15B};
        pushByte(8'h0A);
        pushByte(8'h5A);
        pushByte(8'h07);
        pushByte(8'h0D);
        pushByte(8'h5B);
        waitIdle("cr");
        checks++; if (txQ.size() !== exp.size()) begin errors++; $display("[TB] FAIL cr_count: got %0d required %0d", txQ.size(), exp.size()); end
        else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++; if (txQ[i] !== exp[i]) begin errors++; $display("[TB] FAIL cr_tx%0d: got %h required %h", i, txQ[i], exp[i]); end
            end
        end
        checks++; if (row !== 1'b1 || col !== 5'd1) begin errors++; $display("[TB] FAIL cr_cursor: got %b/%0d required 1/1", row, col); end
        txQ.delete();
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp [$];
        pushByte(8'h0C);
        waitIdle("fill_pre");
        txQ.delete();
        for (int i = 0; i < 16; i++) exp.push_back({2'd1, 8'h61 + 8'(i)});
`ifdef LCD_TEXT_WRITER_AUTOWRAP_EN
        exp.push_back(10'h3C0);
`endif
        @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 15; i++) pushByte(8'h61 + 8'(i));
        checks++; if (charReady !== 1'b1) begin errors++; $display("[TB] FAIL fill_ready15: got %b required 1", charReady); end
        pushByte(8'h70);
        checks++; if (charReady !== 1'b0) begin errors++; $display("[TB] FAIL fill_ready16: got %b required 0", charReady); end
        @(negedge clk);
        charIn    = 8'h7A;
        charValid = 1'b1;
        repeat (3) @(negedge clk);
        charValid = 1'b0;
        checks++; if (charReady !== 1'b0 || txQ.size() !== 0 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL fill_stalled: ready %b tx %0d busy %b required 0 0 1", charReady, txQ.size(), busy);
        end
        stall = 1'b0;
        waitIdle("fill");
        checks++; if (txQ.size() !== exp.size()) begin errors++; $display("[TB] FAIL fill_count: got %0d required %0d", txQ.size(), exp.size()); end
        else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++; if (txQ[i] !== exp[i]) begin errors++; $display("[TB] FAIL fill_tx%0d: got %h required %h", i, txQ[i], exp[i]); end
            end
        end
        txQ.delete();
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        pushByte(8'h0C);
        pushByte(8'h41);
        while (lcdEnb !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++; if (lcdEnb !== 1'b1) begin errors++; $display("[TB] FAIL mid_enb_seen: got %b required 1", lcdEnb); end
        #2;
        rstN = 1'b0;
        txQ.delete();
        #1;
        checks++; if (lcdEnb !== 1'b0 || charReady !== 1'b0) begin errors++; $display("[TB] FAIL mid_async: enb %b ready %b required 0 0", lcdEnb, charReady); end
        checks++; if (row !== 1'b0 || col !== 5'd0 || lcdData !== 8'h00 || lcdOps !== 2'd0) begin
            errors++; $display("[TB] FAIL mid_clear: row %b col %0d data %h ops %0d required 0 0 00 0", row, col, lcdData, lcdOps);
        end
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        waitIdle("mid");
        checks++; if (txQ.size() !== 1) begin errors++; $display("[TB] FAIL mid_count: got %0d required 1", txQ.size()); end
        else begin
            checks++; if (txQ[0] !== 10'h380) begin errors++; $display("[TB] FAIL mid_init_cmd: got %h required 380", txQ[0]); end
        end
        checks++; if (col !== 5'd0 || row !== 1'b0) begin errors++; $display("[TB] FAIL mid_cursor: got %b/%0d required 0/0", row, col); end
        txQ.delete();
    endtask

    initial begin
        test_reset();
        test_hi();
        test_wrap();
        test_controls();
        test_cr_nonprint();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
